// File: rtl/div_sequencer.sv
// ============================================================================
//  Module   : div_sequencer
//  Brief    : Handshake front/back end for the multi-cycle Division unit.
//             Resolves divide-by-zero locally without invoking the divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int WIDTH        = 32,
  parameter int START_CYCLES = 1,
  parameter int DIV_LATENCY  = 34
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_div0,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int C_CNT_MAX = (START_CYCLES > DIV_LATENCY) ? START_CYCLES : DIV_LATENCY;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX + 1) : 1;

  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_CNT_W-1:0] C_CNT_ZERO  = '0;
  localparam logic [C_CNT_W-1:0] C_START_LD  = C_CNT_W'(START_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_WAIT_LD   = C_CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_next;
  logic               w_accept;
  logic               w_b_zero;
  logic               w_capture;

  logic               r_div_start;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_div_a;
  logic [WIDTH-1:0]   r_div_b;
  logic [WIDTH-1:0]   r_out_q;
  logic [WIDTH-1:0]   r_out_r;
  logic               r_out_div0;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_b_zero = (in_b == '0);

  // Next-state and counter logic; w_capture marks the final WAIT cycle.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_b_zero) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_START;
            w_cnt_next = C_START_LD;
          end
        end
      end
      S_START: begin
        if (r_cnt != C_CNT_ZERO) begin
          w_cnt_next = r_cnt - C_CNT_ONE;
        end else begin
          w_cnt_next = C_WAIT_LD;
          w_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != C_CNT_ZERO) begin
          w_cnt_next = r_cnt - C_CNT_ONE;
        end else begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div_start <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_div_start <= (w_next == S_START);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Operand and result registers; out_q/out_r keep their values after the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_a    <= '0;
      r_div_b    <= '0;
      r_out_q    <= '0;
      r_out_r    <= '0;
      r_out_div0 <= 1'b0;
    end else begin
      if (w_accept) begin
        r_div_a <= in_a;
        r_div_b <= in_b;
        if (w_b_zero) begin
          r_out_q    <= '1;
          r_out_r    <= in_a;
          r_out_div0 <= 1'b1;
        end
      end
      if (w_capture) begin
        r_out_q    <= div_q;
        r_out_r    <= div_r;
        r_out_div0 <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = !in_ready;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_r     = r_out_r;
  assign out_div0  = r_out_div0;
  assign div_start = r_div_start;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;

endmodule

`default_nettype wire

// File: tb/tb_div_sequencer.sv
// ============================================================================
//  Module   : tb_div_sequencer
//  Brief    : Self-checking bench for div_sequencer (default and START_CYCLES=3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_sequencer;

  localparam int W   = 32;
  localparam int LAT = 34;
  localparam int SC0 = 1;
  localparam int SC1 = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [1:0][W-1:0] in_a;
  logic [1:0][W-1:0] in_b;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [1:0][W-1:0] out_q;
  logic [1:0][W-1:0] out_r;
  logic [1:0]        out_div0;
  logic [1:0]        busy;
  logic [1:0]        div_start;
  logic [1:0][W-1:0] div_a;
  logic [1:0][W-1:0] div_b;
  logic [1:0][W-1:0] div_q;
  logic [1:0][W-1:0] div_r;

  div_sequencer #(.WIDTH(W), .START_CYCLES(SC0), .DIV_LATENCY(LAT)) dut0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_q(out_q[0]), .out_r(out_r[0]),
    .out_div0(out_div0[0]), .busy(busy[0]), .div_start(div_start[0]),
    .div_a(div_a[0]), .div_b(div_b[0]), .div_q(div_q[0]), .div_r(div_r[0])
  );

  div_sequencer #(.WIDTH(W), .START_CYCLES(SC1), .DIV_LATENCY(LAT)) dut1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_q(out_q[1]), .out_r(out_r[1]),
    .out_div0(out_div0[1]), .busy(busy[1]), .div_start(div_start[1]),
    .div_a(div_a[1]), .div_b(div_b[1]), .div_q(div_q[1]), .div_r(div_r[1])
  );

  // Divider model: results only become valid LAT cycles after div_start falls;
  // before that the outputs show junk so a mistimed capture is visible.
  int dcnt [2];
  initial begin
    dcnt[0] = 0;
    dcnt[1] = 0;
  end
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (div_start[i]) dcnt[i] = 0;
      else if (dcnt[i] < LAT) dcnt[i] = dcnt[i] + 1;
      if (dcnt[i] >= LAT && div_b[i] != '0) begin
        div_q[i] = div_a[i] / div_b[i];
        div_r[i] = div_a[i] % div_b[i];
      end else begin
        div_q[i] = 32'hDEADBEEF;
        div_r[i] = 32'hBAADF00D;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int sc_of(input int idx);
    return (idx == 0) ? SC0 : SC1;
  endfunction

  task automatic start_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clock);
    in_valid[idx] = 1'b1;
    in_a[idx]     = a;
    in_b[idx]     = b;
    while (!in_ready[idx] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected accept", n);
    end
    @(posedge clock);
    #1;
    in_valid[idx] = 1'b0;
    check("div_a_latched", div_a[idx], a);
    check("div_b_latched", div_b[idx], b);
  endtask

  task automatic finish_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                           input int hold, input bit intrude);
    int lat = 0;
    int ds  = 0;
    int exp_lat;
    bit ok_busy = 1'b1;
    bit ok_hold = 1'b1;
    logic [W-1:0] q0, r0;
    exp_lat = (b == '0) ? 1 : sc_of(idx) + LAT + 1;
    while (!out_valid[idx] && lat < 300) begin
      if (div_start[idx]) ds++;
      if (div_a[idx] !== a || div_b[idx] !== b || in_ready[idx] !== 1'b0 || busy[idx] !== 1'b1)
        ok_busy = 1'b0;
      if (intrude && lat == 5) begin
        in_valid[idx] = 1'b1;
        in_a[idx]     = 32'd20;
        in_b[idx]     = 32'd6;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    check("latency", 64'(lat + 1), 64'(exp_lat));
    check("div_start_cycles", 64'(ds), 64'((b == '0) ? 0 : sc_of(idx)));
    if (b != '0) check("operands_stable_busy", 64'(ok_busy), 64'd1);
    check("out_q", out_q[idx], eq);
    check("out_r", out_r[idx], er);
    check("out_div0", out_div0[idx], ed);
    check("in_ready_done", in_ready[idx], 1'b0);
    q0 = out_q[idx];
    r0 = out_r[idx];
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      if (!out_valid[idx] || out_q[idx] !== q0 || out_r[idx] !== r0 ||
          out_div0[idx] !== ed || in_ready[idx] !== 1'b0)
        ok_hold = 1'b0;
    end
    if (hold > 0) check("held_stable", 64'(ok_hold), 64'd1);
    out_ready[idx] = 1'b1;
    @(posedge clock);
    #1;
    out_ready[idx] = 1'b0;
    check("valid_fall", out_valid[idx], 1'b0);
    check("in_ready_back", in_ready[idx], 1'b1);
    check("q_kept", out_q[idx], eq);
    if (intrude) check("intruder_ignored", div_a[idx], a);
  endtask

  task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                       input int hold);
    start_op(idx, a, b);
    finish_op(idx, a, b, eq, er, ed, hold, 1'b0);
  endtask

  typedef struct {
    int         idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int         hold;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       d0;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         md;
    int           sel, cnt_ov;

    vecs[0]  = '{0, 32'd7,          32'd3,          0,  32'd2,          32'd1,     1'b0};
    vecs[1]  = '{0, 32'd100,        32'd0,          0,  32'hFFFFFFFF,   32'd100,   1'b1};
    vecs[2]  = '{0, 32'hFFFFFFFF,   32'd1,          10, 32'hFFFFFFFF,   32'd0,     1'b0};
    vecs[3]  = '{0, 32'd0,          32'd5,          2,  32'd0,          32'd0,     1'b0};
    vecs[4]  = '{0, 32'd5,          32'd7,          1,  32'd0,          32'd5,     1'b0};
    vecs[5]  = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   0,  32'd1,          32'd0,     1'b0};
    vecs[6]  = '{0, 32'd0,          32'd0,          3,  32'hFFFFFFFF,   32'd0,     1'b1};
    vecs[7]  = '{0, 32'd1000,       32'd10,         0,  32'd100,        32'd0,     1'b0};
    vecs[8]  = '{1, 32'd7,          32'd3,          0,  32'd2,          32'd1,     1'b0};
    vecs[9]  = '{1, 32'd12345,      32'd0,          1,  32'hFFFFFFFF,   32'd12345, 1'b1};
    vecs[10] = '{1, 32'h80000000,   32'd3,          2,  32'h2AAAAAAA,   32'd2,     1'b0};

    in_valid  = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", in_ready[i], 1'b1);
      check("rst_busy", busy[i], 1'b0);
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_div_start", div_start[i], 1'b0);
      check("rst_out_q", out_q[i], '0);
      check("rst_out_r", out_r[i], '0);
      check("rst_div0", out_div0[i], 1'b0);
      check("rst_div_a", div_a[i], '0);
      check("rst_div_b", div_b[i], '0);
    end
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 11; v++)
      do_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].d0, vecs[v].hold);

    // Offer 20/6 while the 50/7 operation is in WAIT; it must wait for the handshake.
    start_op(0, 32'd50, 32'd7);
    finish_op(0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b0, 2, 1'b1);
    check("intruder_pending", in_valid[0], 1'b1);
    do_op(0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 0);

    // Reset during WAIT discards the operation immediately.
    start_op(0, 32'd77, 32'd5);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    check("mid_wait_busy", busy[0], 1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_div_start", div_start[0], 1'b0);
    check("rst_mid_out_valid", out_valid[0], 1'b0);
    check("rst_mid_in_ready", in_ready[0], 1'b1);
    @(negedge clock);
    reset = 1'b0;
    cnt_ov = 0;
    repeat (45) begin
      @(posedge clock);
      #1;
      if (out_valid[0] || div_start[0]) cnt_ov++;
    end
    check("no_pulse_after_reset", 64'(cnt_ov), 64'd0);
    do_op(0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0);

    // Randomized operations against a plain-arithmetic reference.
    for (int n = 0; n < 24; n++) begin
      int idx;
      idx = (n % 4 == 3) ? 1 : 0;
      ra  = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 16));
        2:       rb = $urandom;
        default: rb = ra;
      endcase
      if (rb == '0) begin
        mq = '1;
        mr = ra;
        md = 1'b1;
      end else begin
        mq = ra / rb;
        mr = ra % rb;
        md = 1'b0;
      end
      do_op(idx, ra, rb, mq, mr, md, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
